mem_access_stage: RTL and testbench

//  EX->MEM stage of the 5-stage core. Latches the instruction leaving EX, runs loads/stores over a
//  req/ack data-memory handshake and presents a registered MEM/WB result bundle.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_timeout_ctr.sv | 30 +++
 rtl/mem_access_stage.sv | 143 ++++++++++++++
 tb/tb_mem_access_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and sizing for the EX->MEM stage: FSM encoding, latched control bundle,
// default widths and timeout counter sizing.
package mem_stage_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned RD_W        = 3;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_WAIT = 1'b1
  } state_e;

  // Writeback control carried across an outstanding memory access
  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic            halt;
    logic [RD_W-1:0] rd;
  } ctl_t;

  function automatic int unsigned ctr_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding access; expired_c flags the last allowed WAIT cycle.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = ctr_w(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired_c = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// EX->MEM pipeline stage: pass-through for ALU ops, req/ack data-memory access for loads/stores.
// Optional MEM_ALIGN_CHECK_EN: odd-address memory ops complete immediately with err_m.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nop_x,
  input  logic              MemRead_x,
  input  logic              MemWrite_x,
  input  logic              MemToReg_x,
  input  logic              RegWrite_x,
  input  logic [RD_W-1:0]   Rd_x,
  input  logic              halt_x,
  input  logic [DATA_W-1:0] alu_x,
  input  logic [DATA_W-1:0] store_x,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_mem,
  output logic              valid_m,
  output logic              RegWrite_m,
  output logic [RD_W-1:0]   Rd_m,
  output logic [DATA_W-1:0] wb_data_m,
  output logic              halt_m,
  output logic              err_m
);

  state_e state;
  ctl_t   ctl_q;
  logic   mem_op_c;
  logic   illegal_c;
  logic   misalign_c;
  logic   expired_c;
  logic   ctr_clear_c;
  logic   ctr_en_c;

  assign mem_op_c  = MemRead_x ^ MemWrite_x;
  assign illegal_c = MemRead_x & MemWrite_x;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = mem_op_c & alu_x[0];
`else
  assign misalign_c = 1'b0;
`endif

  assign stall_mem   = (state == STATE_WAIT) && !mem_ack;
  assign ctr_clear_c = (state == STATE_IDLE);
  assign ctr_en_c    = (state == STATE_WAIT) && !mem_ack;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (ctr_clear_c),
    .en        (ctr_en_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= STATE_IDLE;
      ctl_q      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      valid_m    <= 1'b0;
      RegWrite_m <= 1'b0;
      Rd_m       <= '0;
      wb_data_m  <= '0;
      halt_m     <= 1'b0;
      err_m      <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          // After a halt every instruction is squashed until reset
          if (halt_m || nop_x) begin
            valid_m <= 1'b0;
            err_m   <= 1'b0;
          end else if (illegal_c || misalign_c) begin
            valid_m    <= 1'b1;
            err_m      <= 1'b1;
            RegWrite_m <= 1'b0;
            Rd_m       <= Rd_x;
            wb_data_m  <= alu_x;
            halt_m     <= halt_x;
          end else if (mem_op_c) begin
            state     <= STATE_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_x;
            mem_addr  <= alu_x;
            mem_wdata <= store_x;
            valid_m   <= 1'b0;
            err_m     <= 1'b0;
            ctl_q     <= '{reg_write: RegWrite_x, mem_to_reg: MemToReg_x,
                           halt: halt_x, rd: Rd_x};
          end else begin
            valid_m    <= 1'b1;
            err_m      <= 1'b0;
            RegWrite_m <= RegWrite_x;
            Rd_m       <= Rd_x;
            wb_data_m  <= alu_x;
            halt_m     <= halt_x;
          end
        end
        STATE_WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle
          if (mem_ack) begin
            state      <= STATE_IDLE;
            mem_req    <= 1'b0;
            valid_m    <= 1'b1;
            err_m      <= 1'b0;
            RegWrite_m <= ctl_q.reg_write;
            Rd_m       <= ctl_q.rd;
            wb_data_m  <= ctl_q.mem_to_reg ? mem_rdata : mem_addr;
            halt_m     <= ctl_q.halt;
          end else if (expired_c) begin
            state      <= STATE_IDLE;
            mem_req    <= 1'b0;
            valid_m    <= 1'b1;
            err_m      <= 1'b1;
            RegWrite_m <= 1'b0;
            Rd_m       <= ctl_q.rd;
            wb_data_m  <= mem_addr;
            halt_m     <= ctl_q.halt;
          end else begin
            valid_m <= 1'b0;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single-cycle ops plus load/store sequences.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        nop_x, MemRead_x, MemWrite_x, MemToReg_x, RegWrite_x, halt_x;
  logic [2:0]  Rd_x;
  logic [15:0] alu_x, store_x;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_mem, valid_m, RegWrite_m, halt_m, err_m;
  logic [2:0]  Rd_m;
  logic [15:0] wb_data_m;

  int n_vec  = 0;
  int n_miss = 0;

  mem_access_stage #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .nop_x(nop_x), .MemRead_x(MemRead_x), .MemWrite_x(MemWrite_x),
    .MemToReg_x(MemToReg_x), .RegWrite_x(RegWrite_x), .Rd_x(Rd_x), .halt_x(halt_x),
    .alu_x(alu_x), .store_x(store_x), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_mem(stall_mem), .valid_m(valid_m), .RegWrite_m(RegWrite_m), .Rd_m(Rd_m),
    .wb_data_m(wb_data_m), .halt_m(halt_m), .err_m(err_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        nop, rd, wr, m2r, rw, ack;
    logic [2:0]  rdx;
    logic [15:0] alu, rdata;
    logic        e_valid, e_rw, e_err;
    logic [2:0]  e_rd;
    logic [15:0] e_wb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic nop, input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic [2:0] rdx, input logic hlt,
                       input logic [15:0] alu, input logic [15:0] st);
    nop_x = nop; MemRead_x = rd; MemWrite_x = wr; MemToReg_x = m2r;
    RegWrite_x = rw; Rd_x = rdx; halt_x = hlt; alu_x = alu; store_x = st;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_req"},   32'(mem_req),   32'd0);
    chk({tag, ".stall_mem"}, 32'(stall_mem), 32'd0);
    chk({tag, ".valid_m"},   32'(valid_m),   32'd0);
    chk({tag, ".RegWrite_m"},32'(RegWrite_m),32'd0);
    chk({tag, ".wb_data_m"}, 32'(wb_data_m), 32'd0);
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, ".halt_m"},    32'(halt_m),    32'd0);
    chk({tag, ".err_m"},     32'(err_m),     32'd0);
  endtask

  initial begin
    //             name       nop rd wr m2r rw ack rdx   alu       rdata     val rw err rd    wb
    vecs[0] = '{"add",       0, 0, 0, 0, 1, 0, 3'd3, 16'h1234, 16'h0000, 1, 1, 0, 3'd3, 16'h1234};
    vecs[1] = '{"nop",       1, 0, 0, 0, 1, 1, 3'd5, 16'hFFFF, 16'h0000, 0, 0, 0, 3'd0, 16'h0000};
    vecs[2] = '{"illegal",   0, 1, 1, 1, 1, 0, 3'd6, 16'h0042, 16'h0000, 1, 0, 1, 3'd6, 16'h0042};
    vecs[3] = '{"idle_ack",  0, 0, 0, 0, 0, 1, 3'd7, 16'hA5A5, 16'hDEAD, 1, 0, 0, 3'd7, 16'hA5A5};
    vecs[4] = '{"alu_m2r",   0, 0, 0, 1, 1, 0, 3'd1, 16'h0F0F, 16'h9999, 1, 1, 0, 3'd1, 16'h0F0F};

    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
    idle();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].nop, vecs[i].rd, vecs[i].wr, vecs[i].m2r, vecs[i].rw, vecs[i].rdx,
            1'b0, vecs[i].alu, 16'h0);
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      tick();
      chk({vecs[i].name, ".valid_m"},   32'(valid_m),   32'(vecs[i].e_valid));
      chk({vecs[i].name, ".mem_req"},   32'(mem_req),   32'd0);
      chk({vecs[i].name, ".stall_mem"}, 32'(stall_mem), 32'd0);
      chk({vecs[i].name, ".err_m"},     32'(err_m),     32'(vecs[i].e_err));
      if (vecs[i].e_valid) begin
        chk({vecs[i].name, ".RegWrite_m"}, 32'(RegWrite_m), 32'(vecs[i].e_rw));
        chk({vecs[i].name, ".Rd_m"},       32'(Rd_m),       32'(vecs[i].e_rd));
        chk({vecs[i].name, ".wb_data_m"},  32'(wb_data_m),  32'(vecs[i].e_wb));
      end
    end
    idle(); mem_ack = 1'b0;
    tick();

    // Load with ack on the 4th WAIT cycle (coincides with timeout count: ack must win)
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 16'h0040, 16'h0);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      chk("ld.mem_req",   32'(mem_req),   32'd1);
      chk("ld.mem_we",    32'(mem_we),    32'd0);
      chk("ld.mem_addr",  32'(mem_addr),  32'h0040);
      chk("ld.stall_mem", 32'(stall_mem), 32'd1);
      chk("ld.valid_m",   32'(valid_m),   32'd0);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    chk("ld.ack_stall", 32'(stall_mem), 32'd0);
    chk("ld.ack_addr",  32'(mem_addr),  32'h0040);
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    chk("ld.done_req",   32'(mem_req),    32'd0);
    chk("ld.done_valid", 32'(valid_m),    32'd1);
    chk("ld.done_wb",    32'(wb_data_m),  32'hBEEF);
    chk("ld.done_rw",    32'(RegWrite_m), 32'd1);
    chk("ld.done_rd",    32'(Rd_m),       32'd5);
    chk("ld.done_err",   32'(err_m),      32'd0);
    tick();
    chk("ld.after_valid", 32'(valid_m), 32'd0);

    // Store never acked: abandoned after 4 WAIT cycles
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0010, 16'h00AA);
    tick();
    idle();
    chk("st.mem_we",    32'(mem_we),    32'd1);
    chk("st.mem_wdata", 32'(mem_wdata), 32'h00AA);
    chk("st.mem_addr",  32'(mem_addr),  32'h0010);
    for (int c = 0; c < 4; c++) begin
      chk("st.wait_req",   32'(mem_req),   32'd1);
      chk("st.wait_stall", 32'(stall_mem), 32'd1);
      tick();
    end
    chk("st.to_req",   32'(mem_req),    32'd0);
    chk("st.to_valid", 32'(valid_m),    32'd1);
    chk("st.to_err",   32'(err_m),      32'd1);
    chk("st.to_rw",    32'(RegWrite_m), 32'd0);
    chk("st.to_stall", 32'(stall_mem),  32'd0);
    tick();
    chk("st.after_err", 32'(err_m), 32'd0);

    // Back-to-back loads, each acked in its first WAIT cycle; upstream holds while stalled
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0100, 16'h0);
    tick();
    chk("b2b.req1",  32'(mem_req),  32'd1);
    chk("b2b.addr1", 32'(mem_addr), 32'h0100);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    chk("b2b.valid1", 32'(valid_m),   32'd1);
    chk("b2b.wb1",    32'(wb_data_m), 32'h1111);
    chk("b2b.rd1",    32'(Rd_m),      32'd1);
    chk("b2b.idle1",  32'(mem_req),   32'd0);
    mem_ack = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 16'h0200, 16'h0);
    tick();
    idle();
    chk("b2b.req2",   32'(mem_req),  32'd1);
    chk("b2b.addr2",  32'(mem_addr), 32'h0200);
    chk("b2b.gap",    32'(valid_m),  32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0;
    chk("b2b.valid2", 32'(valid_m),   32'd1);
    chk("b2b.wb2",    32'(wb_data_m), 32'h2222);
    chk("b2b.rd2",    32'(Rd_m),      32'd2);
    tick();
    chk("b2b.end", 32'(valid_m), 32'd0);

    // Reset asserted mid-WAIT clears everything without a clock edge
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 16'h0030, 16'h0);
    tick();
    idle();
    chk("rstw.req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_zero("rstw");
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'h1234, 16'h0);
    tick();
    idle();
    chk("rstw.add_valid", 32'(valid_m),   32'd1);
    chk("rstw.add_wb",    32'(wb_data_m), 32'h1234);
    chk("rstw.add_req",   32'(mem_req),   32'd0);
    tick();

    // Odd-address load
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 16'h0041, 16'h0);
    tick();
    idle();
`ifdef MEM_ALIGN_CHECK_EN
    chk("odd.req",   32'(mem_req),    32'd0);
    chk("odd.valid", 32'(valid_m),    32'd1);
    chk("odd.err",   32'(err_m),      32'd1);
    chk("odd.rw",    32'(RegWrite_m), 32'd0);
`else
    chk("odd.req",  32'(mem_req),  32'd1);
    chk("odd.addr", 32'(mem_addr), 32'h0041);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    chk("odd.valid", 32'(valid_m),   32'd1);
    chk("odd.wb",    32'(wb_data_m), 32'h5555);
    chk("odd.err",   32'(err_m),     32'd0);
`endif
    tick();

    // Halt is sticky and squashes later instructions
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'h7777, 16'h0);
    tick();
    chk("halt.valid", 32'(valid_m), 32'd1);
    chk("halt.halt",  32'(halt_m),  32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 16'h1111, 16'h0);
    tick();
    chk("halt.sq_valid", 32'(valid_m), 32'd0);
    chk("halt.held",     32'(halt_m),  32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 16'h0080, 16'h0);
    tick();
    chk("halt.sq_req",   32'(mem_req), 32'd0);
    chk("halt.sq_valid2",32'(valid_m), 32'd0);
    rst = 1'b0;
    #1;
    chk("halt.rst", 32'(halt_m), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
